cache_mem_arbiter: RTL
======================

// Module: cache_mem_arbiter
// PURPOSE
//  Parametrised successor to the two-cache miss glue. Arbitrates NUM_REQ cache channels (ch0 = I-cache,
//  ch1 = D-cache, more for future ports) onto one pipelined unified memory port. Runs block fills word by
//  word into the granted cache's arrays and single-cycle write-through stores. Sits between the cache
//  banks and the memory model.
// PARAMETERS
//  NUM_REQ      2   number of requesting cache channels (>=1)
//  ADDR_W       16  byte-address width
//  DATA_W       16  word width; BPW = DATA_W/8 bytes per word
//  BLOCK_WORDS  8   words per cache block (power of 2, >=2); OFF_W = log2(BLOCK_WORDS)
// PORTS
//  clk          in   1               clock
//  rst          in   1               synchronous active-high reset
//  req_miss     in   NUM_REQ         per-channel miss; level, held until that channel's fill_done
//  req_wr       in   NUM_REQ         per-channel write-through store; level, held until wr_ack
//  req_addr     in   NUM_REQ*ADDR_W  packed per-channel address, channel k at [k*ADDR_W +: ADDR_W]
//  req_wdata    in   NUM_REQ*DATA_W  packed per-channel store data
//  mem_rdata    in   DATA_W          memory read data
//  mem_rvalid   in   1               mem_rdata valid; one pulse per issued read, in issue order
//  mem_en       out  1               memory access this cycle
//  mem_wr       out  1               memory write (qualified by mem_en)
//  mem_addr     out  ADDR_W          memory address
//  mem_wdata    out  DATA_W          memory write data
//  fill_we      out  NUM_REQ         one-hot data-array word write
//  fill_word    out  OFF_W           word offset within block for fill_we
//  fill_data    out  DATA_W          fill word (= mem_rdata)
//  fill_tag_we  out  NUM_REQ         one-hot tag/valid write, asserted with the last fill word
//  fill_done    out  NUM_REQ         one-hot 1-cycle pulse, same cycle as fill_tag_we
//  wr_ack       out  NUM_REQ         one-hot 1-cycle pulse, store accepted by memory
//  busy         out  1               state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; issue/receive counters 0; RR pointer 0; all outputs 0.
//  FSM:
//   - IDLE: a channel is pending if req_miss|req_wr. Pick one channel (see CONFIGURATION) and register
//     grant + address. A miss beats a store on the same channel. Miss -> FILL_ISSUE; store -> WRITE;
//     nothing pending -> stay in IDLE.
//   - WRITE (1 cycle): mem_en=1, mem_wr=1, addr/wdata from the granted channel; wr_ack[g]=1 -> IDLE.
//   - FILL_ISSUE: mem_en=1, mem_wr=0, mem_addr = base + iss_cnt*BPW, where base = addr with its low
//     log2(BLOCK_WORDS*BPW) bits cleared. Issue one read per cycle. After read BLOCK_WORDS-1 -> FILL_DRAIN.
//   - FILL_DRAIN: mem_en=0; wait for the remaining returns.
//   - Every mem_rvalid in FILL_*: fill_we[g]=1, fill_word=rx_cnt, fill_data=mem_rdata, rx_cnt++.
//     Returns may overlap issue. The last return (rx_cnt==BLOCK_WORDS-1) also pulses fill_tag_we[g] and
//     fill_done[g]; next state is IDLE.
//  Timing: one IDLE cycle between transactions, minimum. Request seen in cycle 0 -> first memory access
//    in cycle 1.
//  mem_rvalid outside FILL_*: ignored, no output effect (bench flags it as an error).
//  Requester drops req_miss mid-fill: the fill still completes and fill_done still pulses.
//  rst mid-fill: abort to IDLE, counters cleared. The memory is reset by the same rst, so no stale returns.
//  Counters are OFF_W+1 bits and never wrap within a fill. Address adds are modulo 2^ADDR_W.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//   - Rotating priority. Search starts at rr_ptr; after granting channel k, rr_ptr <= (k+1) mod NUM_REQ.
//  ARB_ROUND_ROBIN_EN undefined:
//   - Fixed priority, lowest index wins (I-cache over D-cache). rr_ptr is not built.
// STRUCTURE
//  cache_arb_pkg:
//   - state encoding (IDLE, WRITE, FILL_ISSUE, FILL_DRAIN)
//   - clog2-style helper and derived localparams OFF_W, BPW, BLK_MASK
//  Sub-module req_arbiter (NUM_REQ):
//   - pending vector + optional rr_ptr -> one-hot grant + grant index
//   - purely combinational; rr_ptr register lives in the parent
// TESTING (mock memory: rvalid exactly 4 cycles after each read issue; BLOCK_WORDS=8)
//  1. ch0 miss @0x1234, cycle 0:
//     - reads at 0x1230..0x123E in cycles 1-8
//     - fill_we[0] in cycles 5-12, words 0..7
//     - fill_tag_we[0] + fill_done[0] in cycle 12; busy low in cycle 13
//  2. ch1 store addr 0x0040 data 0xBEEF -> cycle 1: mem_en=1, mem_wr=1, 0x0040/0xBEEF, wr_ack[1]=1.
//     No fill_* activity.
//  3. ch0 and ch1 miss together:
//     - fixed priority: ch0 fill completes first, then ch1 fill starts after one IDLE cycle
//     - RR_EN with both held: grants alternate 0,1,0,1
//  4. ch1 holds req_miss and req_wr together -> fill first; store issued only after fill_done[1].
//  5. rst pulsed at cycle 6 of a fill:
//     - all outputs 0 the next cycle
//     - a new miss restarts at word 0 with correct fill_word
//  6. Stray mem_rvalid in IDLE, and a miss at 0xFFF8 -> no fill_we on the stray; fill wraps to block base
//     0xFFF0.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and size helpers for the cache/memory miss arbiter.
// The OFF_W/BPW/BLK_MASK constants describe the default 8-word, 16-bit build.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE      = 2'd1,
        ST_FILL_ISSUE = 2'd2,
        ST_FILL_DRAIN = 2'd3
    } state_t;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Index width that stays at least one bit for a single-channel build.
    function automatic int idx_w_f(input int n);
        return (n > 1) ? clog2_f(n) : 1;
    endfunction

    localparam int DEF_BLOCK_WORDS = 8;
    localparam int DEF_DATA_W      = 16;
    localparam int OFF_W           = clog2_f(DEF_BLOCK_WORDS);
    localparam int BPW             = DEF_DATA_W / 8;
    localparam int BLK_MASK        = DEF_BLOCK_WORDS * BPW - 1;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle between the cache banks, the memory model and the miss arbiter.
// slave = arbiter view, master = cache/memory environment view.
interface cache_mem_arbiter_if #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8
);
    localparam int WORD_OFF_W = cache_arb_pkg::clog2_f(BLOCK_WORDS);

    logic [NUM_REQ-1:0]        req_miss;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      mem_rvalid;
    logic                      mem_en;
    logic                      mem_wr;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [NUM_REQ-1:0]        fill_we;
    logic [WORD_OFF_W-1:0]     fill_word;
    logic [DATA_W-1:0]         fill_data;
    logic [NUM_REQ-1:0]        fill_tag_we;
    logic [NUM_REQ-1:0]        fill_done;
    logic [NUM_REQ-1:0]        wr_ack;
    logic                      busy;

    modport slave (
        input  req_miss, req_wr, req_addr, req_wdata, mem_rdata, mem_rvalid,
        output mem_en, mem_wr, mem_addr, mem_wdata, fill_we, fill_word, fill_data,
               fill_tag_we, fill_done, wr_ack, busy
    );

    modport master (
        output req_miss, req_wr, req_addr, req_wdata, mem_rdata, mem_rvalid,
        input  mem_en, mem_wr, mem_addr, mem_wdata, fill_we, fill_word, fill_data,
               fill_tag_we, fill_done, wr_ack, busy
    );

endinterface

// File: rtl/req_arbiter.sv
// Combinational channel picker: fixed lowest-index priority, or rotating priority
// starting at rr_ptr when ARB_ROUND_ROBIN_EN is defined.
module req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] pending,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic [IDX_W-1:0]   rr_ptr,
`endif
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

`ifdef ARB_ROUND_ROBIN_EN
    logic [2*NUM_REQ-1:0] rotated;
    logic [IDX_W:0]       sum;

    // Rotate so bit 0 is rr_ptr; lowest set bit of the rotated view wins.
    always_comb begin
        rotated   = {pending, pending} >> rr_ptr;
        sum       = '0;
        gnt_idx   = '0;
        gnt_oh    = '0;
        gnt_valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
                if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
                gnt_idx   = sum[IDX_W-1:0];
                gnt_valid = 1'b1;
            end
        end
        if (gnt_valid) gnt_oh = NUM_REQ'(1) << gnt_idx;
    end
`else
    always_comb begin
        gnt_idx   = '0;
        gnt_oh    = '0;
        gnt_valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                gnt_oh    = '0;
                gnt_oh[i] = 1'b1;
                gnt_idx   = IDX_W'(i);
                gnt_valid = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates cache miss fills and write-through stores onto one pipelined memory port.
// Optional ARB_ROUND_ROBIN_EN selects rotating priority instead of fixed lowest-index priority.
//
// state         | meaning
// ST_IDLE       | no transaction; pick a pending channel
// ST_WRITE      | single-cycle store on the memory port
// ST_FILL_ISSUE | issuing block reads, one per cycle
// ST_FILL_DRAIN | all reads issued, waiting for remaining returns
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8
) (
    input logic                clk,
    input logic                rst,
    cache_mem_arbiter_if.slave bus
);

    localparam int WORD_OFF_W = clog2_f(BLOCK_WORDS);
    localparam int WORD_BYTES = DATA_W / 8;
    localparam int IDX_W      = idx_w_f(NUM_REQ);
    localparam logic [ADDR_W-1:0]   BLOCK_MASK = ADDR_W'(BLOCK_WORDS * WORD_BYTES - 1);
    localparam logic [WORD_OFF_W:0] CNT_LAST   = (WORD_OFF_W+1)'(BLOCK_WORDS - 1);
    localparam logic [WORD_OFF_W:0] CNT_FULL   = (WORD_OFF_W+1)'(BLOCK_WORDS);

    state_t               state;
    logic [NUM_REQ-1:0]   gnt_oh_q;
    logic [ADDR_W-1:0]    base_q;
    logic [WORD_OFF_W:0]  iss_cnt;
    logic [WORD_OFF_W:0]  rx_cnt;
    logic                 mem_en_q;
    logic                 mem_wr_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    mem_wdata_q;
    logic [NUM_REQ-1:0]   wr_ack_q;

    logic [NUM_REQ-1:0]   gnt_oh;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 gnt_valid;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 is_miss;
    logic                 fill_active;
    logic                 rx_fire;
    logic                 rx_last;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]     rr_ptr;
`endif

    req_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_req_arbiter (
        .pending   (bus.req_miss | bus.req_wr),
`ifdef ARB_ROUND_ROBIN_EN
        .rr_ptr    (rr_ptr),
`endif
        .gnt_oh    (gnt_oh),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_idx == IDX_W'(k)) begin
                sel_addr  = bus.req_addr[k*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // A miss on the granted channel takes precedence over its store.
    assign is_miss     = |(gnt_oh & bus.req_miss);
    assign fill_active = (state == ST_FILL_ISSUE) || (state == ST_FILL_DRAIN);
    assign rx_fire     = fill_active && bus.mem_rvalid;
    assign rx_last     = rx_fire && (rx_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            gnt_oh_q    <= '0;
            base_q      <= '0;
            iss_cnt     <= '0;
            rx_cnt      <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wr_ack_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        gnt_oh_q <= gnt_oh;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_ptr   <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
`endif
                        if (is_miss) begin
                            state      <= ST_FILL_ISSUE;
                            mem_en_q   <= 1'b1;
                            mem_wr_q   <= 1'b0;
                            mem_addr_q <= sel_addr & ~BLOCK_MASK;
                            base_q     <= sel_addr & ~BLOCK_MASK;
                            iss_cnt    <= (WORD_OFF_W+1)'(1);
                            rx_cnt     <= '0;
                        end else begin
                            state       <= ST_WRITE;
                            mem_en_q    <= 1'b1;
                            mem_wr_q    <= 1'b1;
                            mem_addr_q  <= sel_addr;
                            mem_wdata_q <= sel_wdata;
                            wr_ack_q    <= gnt_oh;
                        end
                    end
                end
                ST_WRITE: begin
                    state    <= ST_IDLE;
                    mem_en_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                    wr_ack_q <= '0;
                end
                ST_FILL_ISSUE: begin
                    if (iss_cnt == CNT_FULL) begin
                        state    <= ST_FILL_DRAIN;
                        mem_en_q <= 1'b0;
                    end else begin
                        mem_addr_q <= base_q + ADDR_W'(iss_cnt) * ADDR_W'(WORD_BYTES);
                        iss_cnt    <= iss_cnt + (WORD_OFF_W+1)'(1);
                    end
                end
                default: ;
            endcase

            // Returns can overlap issue; the final one closes the fill from either fill state.
            if (rx_fire) begin
                rx_cnt <= rx_cnt + (WORD_OFF_W+1)'(1);
                if (rx_last) begin
                    state    <= ST_IDLE;
                    mem_en_q <= 1'b0;
                    rx_cnt   <= '0;
                    iss_cnt  <= '0;
                end
            end
        end
    end

    assign bus.mem_en      = mem_en_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.wr_ack      = wr_ack_q;
    assign bus.fill_we     = rx_fire ? gnt_oh_q : '0;
    assign bus.fill_word   = rx_cnt[WORD_OFF_W-1:0];
    assign bus.fill_data   = bus.mem_rdata;
    assign bus.fill_tag_we = rx_last ? gnt_oh_q : '0;
    assign bus.fill_done   = rx_last ? gnt_oh_q : '0;
    assign bus.busy        = (state != ST_IDLE);

endmodule
